region_guard: RTL
=================

Name: region_guard

Overview:
- Parametrised successor to the single-policy execution-aware access monitor in the active RoT.
- Watches the CPU program counter and data bus against N configurable protected data regions, each with independent read/write protection.
- Optionally confines writes made by trusted code to an allow-list of regions.
- Drives a registered kill/reset line that is held for a minimum time and then released only on a clean fetch of the reset handler.
- Latches cause, address, PC and a saturating episode count for the RoT firmware.

Parameters:
- ADDR_W, 16: width of pc and data_addr.
- N_REGIONS, 3: number of protected regions.
- REGION_BASE, {16'hFFC0,16'h6A00,16'h0B00}: packed N*ADDR_W. Inclusive first address; region 0 in the LSBs.
- REGION_LAST, {16'hFFDF,16'h6A1F,16'h16FF}: packed N*ADDR_W. Inclusive last address.
- REGION_RD_MASK, 3'b011: bit i=1 means untrusted reads of region i are violations.
- REGION_WR_MASK, 3'b111: bit i=1 means untrusted writes to region i are violations.
- TRUST_BASE, 16'hA100: first address of trusted code (inclusive).
- TRUST_LAST, 16'hBFFE: last address of trusted code (inclusive).
- CONFINE_TRUSTED_WR, 0: 1 enables the trusted-write confinement check.
- TRUSTED_WR_MASK, 3'b101: regions trusted code may write when confinement is on.
- RESET_HANDLER, 16'hFFFE: PC value that permits release.
- KILL_MIN_CYCLES, 4: minimum kill assertion in cycles; must be ≥1.
- CNT_W, 8: width of the episode counter.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous, active-low reset.
- pc, input, ADDR_W: current program counter.
- data_addr, input, ADDR_W: data bus address.
- r_en, input, 1: data read strobe.
- w_en, input, 1: data write strobe.
- kill, output, 1: registered reset request to the core.
- viol_region, output, N_REGIONS: captured per-region violation vector.
- viol_confine, output, 1: captured confinement-violation flag.
- viol_addr, output, ADDR_W: captured data_addr.
- viol_pc, output, ADDR_W: captured pc.
- viol_cnt, output, CNT_W: saturating count of kill episodes.

Behaviour:
Combinational decode:
- trusted = TRUST_BASE ≤ pc ≤ TRUST_LAST.
- hit[i] = BASE[i] ≤ data_addr ≤ LAST[i], unsigned compare, both bounds inclusive.
- rv[i] = !trusted & hit[i] & ((r_en & RD_MASK[i]) | (w_en & WR_MASK[i])).
- cv = CONFINE_TRUSTED_WR & trusted & w_en & ~|(hit & TRUSTED_WR_MASK).
- any_viol = |rv | cv.
- With r_en=w_en=0 there is never a violation.

State machine (RUN, KILL), advancing on posedge clk:
- RUN → KILL when any_viol. On that edge:
  - kill ← 1.
  - hold_cnt ← KILL_MIN_CYCLES-1.
  - viol_region ← rv, viol_confine ← cv, viol_addr ← data_addr, viol_pc ← pc.
  - viol_cnt ← viol_cnt+1, saturating at all-ones.
- KILL with hold_cnt ≠ 0: hold_cnt decrements; the state does not exit.
- KILL → RUN when hold_cnt==0 & pc==RESET_HANDLER & !any_viol. On that edge kill ← 0.
- Otherwise the state and kill are held.

Timing and capture rules:
- Latency: kill rises at the first edge that samples a violation and stays high for at least KILL_MIN_CYCLES cycles.
- Violations in KILL do not reload hold_cnt, do not update the capture registers and do not increment viol_cnt. They only block exit.
- pc==RESET_HANDLER together with a violation in the same cycle: stay in KILL.
- Capture registers persist after return to RUN until the next episode overwrites them.
- Several regions hitting at once (overlapping regions) set multiple bits in viol_region.

Reset (rst_n low, asynchronous, including mid-KILL):
- state=RUN, kill=0, hold_cnt=0.
- viol_region=0, viol_confine=0, viol_addr=0, viol_pc=0, viol_cnt=0.

Decomposition:
- Shared package region_guard_pkg holds:
  - State encoding: RUN=1'b0, KILL=1'b1.
  - Default memory-map constants (SDATA, KMEM, CTR, SMEM, RESET_HANDLER) so all RoT monitors use one map.
  - A helper that extracts field i of a packed parameter vector.
- One natural sub-module, region_match: one region's inclusive range compare plus its rv bit. Instantiate it N_REGIONS times in a generate loop.
- The FSM, hold counter and capture logic stay in the top level.

Test Plan (default parameters unless stated):
1. Untrusted read of region 0: pc=0xE000, data_addr=0x0C00, r_en=1 for one cycle.
   - kill=1 at the next edge.
   - viol_region=3'b001, viol_addr=0x0C00, viol_pc=0xE000, viol_cnt=1.
2. Minimum hold and release: after test 1, drive pc=0xFFFE with no strobes.
   - kill stays high for exactly 4 cycles, then falls.
   - Repeat with w_en=1, data_addr=0x0C00 in the release cycle: kill stays 1 until a clean pc=0xFFFE cycle.
3. Trust and per-region policy:
   - pc=0xA200 reads and writes 0x0C00: no kill.
   - pc=0xE000 reads 0xFFC5: no kill (RD_MASK bit2=0).
   - pc=0xE000 writes 0xFFC5: kill, viol_region=3'b100.
4. Boundaries, untrusted writes:
   - data_addr 0x0AFF and 0x1700: no kill. 0x0B00 and 0x16FF: kill.
   - Writing 0x0C00 from pc=0xA0FF: kill. Writing it from pc=0xBFFE: no kill.
5. CONFINE_TRUSTED_WR=1, pc=0xA200:
   - Write to 0x6A00: kill, viol_confine=1, viol_region=0.
   - Write to 0x0C00 or 0x2000: no kill for 0x0C00; kill with viol_confine=1 for 0x2000.
6. Reset and counter saturation:
   - Assert rst_n=0 mid-KILL: kill=0 with no clock edge and all captures cleared.
   - Run 300 episodes: viol_cnt saturates at 255 and stays there.

Source files
------------

// File: rtl/region_guard_pkg.sv
// Shared definitions for the RoT access monitors: FSM encoding, the default
// memory map, and a helper for slicing packed per-region parameter vectors.
package region_guard_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    KILL = 1'b1
  } state_e;

  // Default RoT memory map, shared by every monitor instance.
  localparam logic [15:0] SDATA_BASE         = 16'h0B00;
  localparam logic [15:0] SDATA_LAST         = 16'h16FF;
  localparam logic [15:0] KMEM_BASE          = 16'h6A00;
  localparam logic [15:0] KMEM_LAST          = 16'h6A1F;
  localparam logic [15:0] CTR_BASE           = 16'hFFC0;
  localparam logic [15:0] CTR_LAST           = 16'hFFDF;
  localparam logic [15:0] SMEM_BASE          = 16'hA100;
  localparam logic [15:0] SMEM_LAST          = 16'hBFFE;
  localparam logic [15:0] RESET_HANDLER_ADDR = 16'hFFFE;

  // Widest packed vector / field the helper accepts.
  localparam int FIELD_VEC_W = 256;
  localparam int FIELD_W     = 32;

  // Return field idx (each width bits wide, field 0 in the LSBs) of vec.
  function automatic logic [FIELD_W-1:0] field_of(input logic [FIELD_VEC_W-1:0] vec,
                                                  input int idx,
                                                  input int width);
    logic [FIELD_VEC_W-1:0] shifted;
    logic [FIELD_W-1:0]     mask;
    shifted = vec >> (idx * width);
    mask    = (FIELD_W'(1) << width) - FIELD_W'(1);
    return shifted[FIELD_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/region_guard_region_match.sv
// One protected region: inclusive range compare on the data address and the
// resulting untrusted-access violation bit for this region.
module region_match
  import region_guard_pkg::*;
#(
  parameter int              ADDR_W  = 16,
  parameter logic [ADDR_W-1:0] BASE  = SDATA_BASE,
  parameter logic [ADDR_W-1:0] LAST  = SDATA_LAST,
  parameter bit              RD_PROT = 1'b1,
  parameter bit              WR_PROT = 1'b1
) (
  input  logic [ADDR_W-1:0] data_addr,
  input  logic              untrusted,
  input  logic              r_en,
  input  logic              w_en,
  output logic              hit,
  output logic              rv
);

  // Both bounds are inclusive, unsigned compare.
  assign hit = (data_addr >= BASE) && (data_addr <= LAST);

  // Only strobed accesses from untrusted code matching this region's policy.
  assign rv = untrusted & hit & ((r_en & RD_PROT) | (w_en & WR_PROT));

endmodule

// File: rtl/region_guard.sv
// Execution-aware access monitor: checks pc/data bus against N protected
// regions, drives a held kill line released only by a clean reset-handler
// fetch, and latches cause/address/pc plus a saturating episode count.
module region_guard
  import region_guard_pkg::*;
#(
  parameter int                          ADDR_W             = 16,
  parameter int                          N_REGIONS          = 3,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE        = {CTR_BASE, KMEM_BASE, SDATA_BASE},
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_LAST        = {CTR_LAST, KMEM_LAST, SDATA_LAST},
  parameter logic [N_REGIONS-1:0]        REGION_RD_MASK     = 3'b011,
  parameter logic [N_REGIONS-1:0]        REGION_WR_MASK     = 3'b111,
  parameter logic [ADDR_W-1:0]           TRUST_BASE         = SMEM_BASE,
  parameter logic [ADDR_W-1:0]           TRUST_LAST         = SMEM_LAST,
  parameter bit                          CONFINE_TRUSTED_WR = 1'b0,
  parameter logic [N_REGIONS-1:0]        TRUSTED_WR_MASK    = 3'b101,
  parameter logic [ADDR_W-1:0]           RESET_HANDLER      = RESET_HANDLER_ADDR,
  parameter int                          KILL_MIN_CYCLES    = 4,
  parameter int                          CNT_W              = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_W-1:0]    pc,
  input  logic [ADDR_W-1:0]    data_addr,
  input  logic                 r_en,
  input  logic                 w_en,
  output logic                 kill,
  output logic [N_REGIONS-1:0] viol_region,
  output logic                 viol_confine,
  output logic [ADDR_W-1:0]    viol_addr,
  output logic [ADDR_W-1:0]    viol_pc,
  output logic [CNT_W-1:0]     viol_cnt
);

  localparam int HOLD_W = (KILL_MIN_CYCLES > 1) ? $clog2(KILL_MIN_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(KILL_MIN_CYCLES - 1);

  logic                 trusted;
  logic [N_REGIONS-1:0] hit;
  logic [N_REGIONS-1:0] rv;
  logic                 cv;
  logic                 any_viol;
  logic                 enter_kill;
  state_e               state_q, state_d;
  logic [HOLD_W-1:0]    hold_q;

  assign trusted = (pc >= TRUST_BASE) && (pc <= TRUST_LAST);

  for (genvar i = 0; i < N_REGIONS; i++) begin : g_region
    localparam logic [ADDR_W-1:0] BASE_I =
      ADDR_W'(field_of(FIELD_VEC_W'(REGION_BASE), i, ADDR_W));
    localparam logic [ADDR_W-1:0] LAST_I =
      ADDR_W'(field_of(FIELD_VEC_W'(REGION_LAST), i, ADDR_W));

    region_match #(
      .ADDR_W  (ADDR_W),
      .BASE    (BASE_I),
      .LAST    (LAST_I),
      .RD_PROT (REGION_RD_MASK[i]),
      .WR_PROT (REGION_WR_MASK[i])
    ) u_match (
      .data_addr (data_addr),
      .untrusted (!trusted),
      .r_en      (r_en),
      .w_en      (w_en),
      .hit       (hit[i]),
      .rv        (rv[i])
    );
  end

  // Trusted writes outside the allow-list, then the combined violation.
  always_comb begin
    cv       = CONFINE_TRUSTED_WR && trusted && w_en && !(|(hit & TRUSTED_WR_MASK));
    any_viol = (|rv) | cv;
  end

  // State register; the single state bit is the registered kill line.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Next state: enter on any violation, leave only after the hold expires on a clean handler fetch.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      RUN:  if (any_viol) state_d = KILL;
      KILL: if ((hold_q == '0) && (pc == RESET_HANDLER) && !any_viol) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Outputs of the FSM: kill level and the one-cycle episode-start strobe.
  always_comb begin
    kill       = (state_q == KILL);
    enter_kill = (state_q == RUN) && any_viol;
  end

  // Minimum-hold counter: loaded on entry, counts down while killed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           hold_q <= '0;
    else if (enter_kill)                  hold_q <= HOLD_LOAD;
    else if (kill && (hold_q != '0))      hold_q <= hold_q - HOLD_W'(1);
  end

  // Capture cause and count episodes; only the entry edge updates them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      viol_region  <= '0;
      viol_confine <= 1'b0;
      viol_addr    <= '0;
      viol_pc      <= '0;
      viol_cnt     <= '0;
    end else if (enter_kill) begin
      viol_region  <= rv;
      viol_confine <= cv;
      viol_addr    <= data_addr;
      viol_pc      <= pc;
      if (viol_cnt != '1) viol_cnt <= viol_cnt + CNT_W'(1);
    end
  end

endmodule
